uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one 8N1 UART transmitter among `N` byte requesters. It accepts one byte at a time over a per-channel request/acknowledge handshake and drives the transmitter's send-request edge and data bus. It then tracks the transmitter's sending-finish flag through the whole frame before granting the next channel. It sits between the system's byte producers and the `UART` instance's `iT`/`iTDATA`/`oT` pins.

---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_ctrl_pkg: shared definitions for the UART transmit arbiter.
//   - one-hot state encodings and the FSM state type
//   - default transmitter-response timeout and inter-frame gap
//   - counter width used by the gap / timeout counters
package uart_ctrl_pkg;

  localparam logic [3:0] ST_GAP_OH  = 4'b0001;
  localparam logic [3:0] ST_IDLE_OH = 4'b0010;
  localparam logic [3:0] ST_REQ_OH  = 4'b0100;
  localparam logic [3:0] ST_SEND_OH = 4'b1000;

  typedef enum logic [3:0] {
    ST_GAP  = ST_GAP_OH,
    ST_IDLE = ST_IDLE_OH,
    ST_REQ  = ST_REQ_OH,
    ST_SEND = ST_SEND_OH
  } arb_state_t;

  localparam int DEF_ACK_TO  = 16;
  localparam int DEF_GAP_CYC = 4;

  // Wide enough for any sensible ACK_TO / GAP_CYC.
  localparam int CNT_W = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus UART transmitter pins.
//   iREQ/iDATA/oACK : per-channel byte request / accept
//   oGNT/oBUSY/oERR : arbiter status
//   oUT/oUTDATA     : to UART iT / iTDATA
//   iUT             : from UART oT (high = transmitter idle)
// master: the environment (requesters + UART); slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  localparam int GW = $clog2(N);

  logic [N-1:0]   iREQ;
  logic [8*N-1:0] iDATA;
  logic [N-1:0]   oACK;
  logic [GW-1:0]  oGNT;
  logic           oBUSY;
  logic           oERR;
  logic           oUT;
  logic [7:0]     oUTDATA;
  logic           iUT;

  modport master (
    output iREQ, iDATA, iUT,
    input  oACK, oGNT, oBUSY, oERR, oUT, oUTDATA
  );

  modport slave (
    input  iREQ, iDATA, iUT,
    output oACK, oGNT, oBUSY, oERR, oUT, oUTDATA
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
//   req   : per-channel request vector
//   ptr   : last granted channel
//   valid : at least one request present
//   idx   : first requesting channel searching upward from ptr+1, wrapping
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);

  always_comb begin
    int          c;
    logic [W-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    cand  = '0;
    // Offset N revisits ptr itself, so a lone requester equal to ptr still wins.
    for (int off = 1; off <= N; off++) begin
      c = int'(ptr) + off;
      if (c >= N) c = c - N;
      cand = c[W-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter among N byte requesters.
//   iCLK   : system clock (rising edge)
//   iRST_N : synchronous active-low reset
//   bus    : requester handshake and UART pins (slave modport)
// Parameters: N requesters, ACK_TO cycles to wait for the transmitter to go
// busy, GAP_CYC cycles of oUT low before the next send-request edge.
//
// state | meaning
// GAP   | oUT low, let the UART iT synchroniser see the low level
// IDLE  | accept the round-robin winner's byte
// REQ   | oUT high, waiting for iUT low (frame started)
// SEND  | frame in progress, waiting for iUT high
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int ACK_TO  = DEF_ACK_TO,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input logic              iCLK,
  input logic              iRST_N,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(N);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TO - 1);

  arb_state_t       state, state_n;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_n;
  logic [CNT_W-1:0] to_cnt, to_cnt_n;
  logic [GW-1:0]    ptr, ptr_n;
  logic [N-1:0]     ack_q, ack_n;
  logic [GW-1:0]    gnt_q, gnt_n;
  logic             err_q, err_n;
  logic             ut_q, ut_n;
  logic [7:0]       utdata_q, utdata_n;

  logic             pick_valid;
  logic [GW-1:0]    pick_idx;
  logic [7:0]       pick_byte;

  rr_pick #(.N(N)) u_rr_pick (
    .req   (bus.iREQ),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_byte = '0;
    for (int k = 0; k < N; k++) begin
      if (pick_idx == GW'(k)) pick_byte = bus.iDATA[8*k +: 8];
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state    <= ST_GAP;
      gap_cnt  <= '0;
      to_cnt   <= '0;
      ptr      <= GW'(N - 1);
      ack_q    <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      ut_q     <= 1'b0;
      utdata_q <= '0;
    end else begin
      state    <= state_n;
      gap_cnt  <= gap_cnt_n;
      to_cnt   <= to_cnt_n;
      ptr      <= ptr_n;
      ack_q    <= ack_n;
      gnt_q    <= gnt_n;
      err_q    <= err_n;
      ut_q     <= ut_n;
      utdata_q <= utdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    to_cnt_n  = to_cnt;
    ptr_n     = ptr;
    ack_n     = '0;
    gnt_n     = gnt_q;
    err_n     = 1'b0;
    ut_n      = ut_q;
    utdata_n  = utdata_q;

    unique case (state)
      ST_GAP: begin
        ut_n = 1'b0;
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_n = '0;
          state_n   = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end

      ST_IDLE: begin
        if (pick_valid) begin
          utdata_n        = pick_byte;
          ack_n[pick_idx] = 1'b1;
          gnt_n           = pick_idx;
          ptr_n           = pick_idx;
          ut_n            = 1'b1;
          to_cnt_n        = '0;
          state_n         = ST_REQ;
        end
      end

      ST_REQ: begin
        if (!bus.iUT) begin
          ut_n    = 1'b0;
          state_n = ST_SEND;
        end else if (to_cnt == TO_LAST) begin
          // Transmitter never went busy: drop the byte and flag it.
          ut_n      = 1'b0;
          err_n     = 1'b1;
          gap_cnt_n = '0;
          state_n   = ST_GAP;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end

      ST_SEND: begin
        ut_n = 1'b0;
        if (bus.iUT) begin
          gap_cnt_n = '0;
          state_n   = ST_GAP;
        end
      end

      default: begin
        ut_n      = 1'b0;
        gap_cnt_n = '0;
        state_n   = ST_GAP;
      end
    endcase
  end

  assign bus.oACK    = ack_q;
  assign bus.oGNT    = gnt_q;
  assign bus.oERR    = err_q;
  assign bus.oUT     = ut_q;
  assign bus.oUTDATA = utdata_q;
  assign bus.oBUSY   = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. The UART transmitter is stood in for by a small
// model: 3-stage iT synchroniser, rising edge starts a FRAME-cycle frame with
// oT low, the byte on iTDATA is captured at frame start.
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int ACK_TO  = 16;
  localparam int GAP_CYC = 4;
  localparam int FRAME   = 100;  // 10 bits x 10 cycles/bit

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .ACK_TO(ACK_TO), .GAP_CYC(GAP_CYC)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus.slave)
  );

  // Transmitter model
  logic       force_hi;
  logic [2:0] sync_q = '0;
  logic       sync_d = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] rx_mem [0:63];
  int         rx_cnt = 0;

  always @(posedge clk) begin
    sync_q <= {sync_q[1:0], bus.oUT};
    sync_d <= sync_q[2];
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (sync_q[2] && !sync_d && !force_hi) begin
      busy_cnt       <= FRAME;
      rx_mem[rx_cnt] <= bus.oUTDATA;
      rx_cnt         <= rx_cnt + 1;
    end
  end
  assign bus.iUT = force_hi | (busy_cnt == 0);

  int checks = 0;
  int failures = 0;
  logic [N-1:0] sticky;
  int ack_ch  [0:63];
  logic [7:0] ack_dat [0:63];
  int ack_cnt = 0;
  int err_cnt = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample at negedge, log acks/errors, requesters drop on ack.
  task automatic tick();
    @(negedge clk);
    if (bus.oACK != '0) begin
      chk_val("ack_onehot", $countones(bus.oACK), 1);
      for (int k = 0; k < N; k++) begin
        if (bus.oACK[k]) begin
          if (ack_cnt < 64) begin
            ack_ch[ack_cnt]  = k;
            ack_dat[ack_cnt] = bus.oUTDATA;
          end
          ack_cnt++;
          if (!sticky[k]) bus.iREQ[k] = 1'b0;
        end
      end
    end
    if (bus.oERR) err_cnt++;
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (bus.oACK != '0) break;
    end
    if (i == budget) chk_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_acks(input string tag, input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (ack_cnt >= target) break;
      tick();
    end
    if (i == budget) chk_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ut(input string tag, input logic lvl, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (bus.iUT == lvl) break;
      tick();
    end
    if (i == budget) chk_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (!bus.oBUSY && bus.iUT) break;
      tick();
    end
    if (i == 2000) chk_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk_val({tag, "_ut"},     bus.oUT, 0);
    chk_val({tag, "_utdata"}, bus.oUTDATA, 0);
    chk_val({tag, "_ack"},    bus.oACK, 0);
    chk_val({tag, "_gnt"},    bus.oGNT, 0);
    chk_val({tag, "_err"},    bus.oERR, 0);
    chk_val({tag, "_busy"},   bus.oBUSY, 1);
  endtask

  initial begin
    int n, base, rx0, e0;
    int exp_rr [4];
    rst_n    = 1'b0;
    force_hi = 1'b0;
    sticky   = '0;
    bus.iREQ  = '0;
    bus.iDATA = '0;
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1'b1;

    // 1: ch2 alone
    rx0 = rx_cnt;
    bus.iDATA[23:16] = 8'hA5;
    bus.iREQ[2] = 1'b1;
    wait_ack("t1_ack", 100);
    chk_val("t1_ack", bus.oACK, 4'b0100);
    chk_val("t1_gnt", bus.oGNT, 2);
    chk_val("t1_utdata", bus.oUTDATA, 8'hA5);
    wait_ut("t1_ut_low", 1'b0, 100);
    wait_ut("t1_ut_high", 1'b1, 500);
    chk_val("t1_utdata_hold", bus.oUTDATA, 8'hA5);
    // One cycle for the arbiter to sample iUT, then GAP_CYC cycles of GAP.
    n = 0;
    while (bus.oBUSY && n < 50) begin tick(); n++; end
    chk_val("t1_busy_fall", n, GAP_CYC + 1);
    chk_val("t1_rx_cnt", rx_cnt - rx0, 1);
    chk_val("t1_rx", rx_mem[rx0], 8'hA5);

    // 2: all four after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.iDATA = {8'h44, 8'h33, 8'h22, 8'h11};
    base = ack_cnt;
    rx0  = rx_cnt;
    bus.iREQ = 4'hF;
    wait_acks("t2_acks", base + 4, 3000);
    wait_idle("t2_idle");
    repeat (5) tick();
    chk_val("t2_ack_cnt", ack_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk_val($sformatf("t2_gnt%0d", i), ack_ch[base+i], i);
      chk_val($sformatf("t2_rx%0d", i), rx_mem[rx0+i], 8'h11 * (i + 1));
    end

    // 3: ch0 and ch3 continuous; pointer is at 3 after test 2
    exp_rr = '{0, 3, 0, 3};
    sticky = 4'b1001;
    base = ack_cnt;
    bus.iREQ = 4'b1001;
    wait_acks("t3_acks", base + 4, 3000);
    sticky = '0;
    bus.iREQ = '0;
    wait_idle("t3_idle");
    for (int i = 0; i < 4; i++)
      chk_val($sformatf("t3_gnt%0d", i), ack_ch[base+i], exp_rr[i]);

    // 4: transmitter never goes busy
    force_hi = 1'b1;
    base = ack_cnt;
    e0   = err_cnt;
    bus.iDATA[15:8] = 8'h5A;
    bus.iREQ[1] = 1'b1;
    wait_ack("t4_ack", 100);
    chk_val("t4_ack", bus.oACK, 4'b0010);
    n = 0;
    while (bus.oUT && n < 100) begin tick(); n++; end
    chk_val("t4_ut_high", n, ACK_TO);
    chk_val("t4_err", bus.oERR, 1);
    chk_val("t4_ut_low", bus.oUT, 0);
    chk_val("t4_ack1_once", ack_cnt - base, 1);
    bus.iREQ[1] = 1'b1;
    tick();
    chk_val("t4_err_pulse", bus.oERR, 0);
    n = 1;
    while (bus.oACK == '0 && n < 50) begin tick(); n++; end
    chk_val("t4_next_accept", n, GAP_CYC + 1);
    n = 0;
    while (err_cnt - e0 < 2 && n < 100) begin tick(); n++; end
    chk_val("t4_err_cnt", err_cnt - e0, 2);
    force_hi = 1'b0;
    wait_idle("t4_idle");

    // 5: reset mid-frame with ch1 pending
    bus.iDATA[15:8] = 8'hC3;
    bus.iREQ[1] = 1'b1;
    wait_ack("t5_ack", 100);
    wait_ut("t5_ut_low", 1'b0, 100);
    repeat (5) tick();
    bus.iREQ[1] = 1'b1;
    base = ack_cnt;
    e0   = err_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("t5_rst");
    n = 0;
    while (bus.oACK == '0 && n < 50) begin tick(); n++; end
    chk_val("t5_accept_lat", n, GAP_CYC + 1);
    chk_val("t5_ack_cnt", ack_cnt - base, 1);
    chk_val("t5_no_err", err_cnt - e0, 0);
    wait_idle("t5_idle");

    // 6: ch0 held across reset release and GAP
    rst_n = 1'b0;
    base = ack_cnt;
    bus.iDATA[7:0] = 8'h77;
    bus.iREQ[0] = 1'b1;
    repeat (3) tick();
    chk_val("t6_no_ack_rst", ack_cnt - base, 0);
    rst_n = 1'b1;
    n = 0;
    while (bus.oACK == '0 && n < 50) begin tick(); n++; end
    chk_val("t6_first_ack", n, GAP_CYC + 1);
    chk_val("t6_utdata", bus.oUTDATA, 8'h77);
    wait_idle("t6_idle");
    repeat (5) tick();
    chk_val("t6_one_ack", ack_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
